// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, stable-time filter,
// registered level plus press, release and long-press/auto-repeat ticks.
module debounce_multi #(
   parameter int              CH            = 4,
   parameter int              DB_CYCLES     = 2000000,
   parameter int              SYNC_STAGES   = 2,
   parameter int              HOLD_CYCLES   = 50000000,
   parameter int              REPEAT_CYCLES = 10000000,
   parameter logic [CH-1:0]   ACTIVE_LOW    = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CH-1:0] sw,
   output logic [CH-1:0] db_level,
   output logic [CH-1:0] rise_tick,
   output logic [CH-1:0] fall_tick,
   output logic [CH-1:0] hold_tick
);

   localparam int CW   = $clog2(DB_CYCLES);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         ((HOLD_CYCLES > 1) ? HOLD_CYCLES : 1) :
                         ((REPEAT_CYCLES > 1) ? REPEAT_CYCLES : 1);
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [CW-1:0] CNT_LOAD  = CW'(DB_CYCLES - 2);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      state_t                 state, state_next;
      logic [CW-1:0]          cnt, cnt_next;
      logic [HW-1:0]          hcnt, hcnt_next;
      logic                   repeating, repeating_next;
      logic                   level_q, rise_q, fall_q, hold_q;
      logic                   level_next, rise_next, fall_next, hold_next;

      assign s = sync[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync <= '0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], sw[g] ^ ACTIVE_LOW[g]};
         end
      end

      // Any contrary sample while qualifying sends the channel back to its settled state.
      always_comb begin
         state_next = state;
         cnt_next   = cnt;
         case (state)
            ZERO: begin
               if (s) begin
                  state_next = WAIT1;
                  cnt_next   = CNT_LOAD;
               end
            end
            WAIT1: begin
               if (!s)                state_next = ZERO;
               else if (cnt == '0)    state_next = ONE;
               else                   cnt_next   = cnt - CW'(1);
            end
            ONE: begin
               if (!s) begin
                  state_next = WAIT0;
                  cnt_next   = CNT_LOAD;
               end
            end
            WAIT0: begin
               if (s)                 state_next = ONE;
               else if (cnt == '0)    state_next = ZERO;
               else                   cnt_next   = cnt - CW'(1);
            end
            default: begin
               state_next = ZERO;
               cnt_next   = '0;
            end
         endcase
         level_next = (state_next == ONE) || (state_next == WAIT0);
         rise_next  = level_next && !level_q;
         fall_next  = !level_next && level_q;
      end

      // Hold ticks are gated by the next level so a release always beats a hold expiry.
      always_comb begin
         hcnt_next      = hcnt;
         repeating_next = repeating;
         hold_next      = 1'b0;
         if (!level_q) begin
            hcnt_next      = '0;
            repeating_next = 1'b0;
         end else if (HOLD_CYCLES > 0) begin
            if (repeating) begin
               if (hcnt >= REP_LAST) begin
                  hcnt_next = '0;
                  hold_next = level_next;
               end else begin
                  hcnt_next = hcnt + HW'(1);
               end
            end else if (hcnt == HOLD_LAST) begin
               hold_next = level_next;
               if (REPEAT_CYCLES > 0) begin
                  hcnt_next      = '0;
                  repeating_next = 1'b1;
               end else begin
                  hcnt_next = HOLD_SAT;
               end
            end else if (hcnt < HOLD_SAT) begin
               hcnt_next = hcnt + HW'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state     <= ZERO;
            cnt       <= '0;
            hcnt      <= '0;
            repeating <= 1'b0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            hold_q    <= 1'b0;
         end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            hcnt      <= hcnt_next;
            repeating <= repeating_next;
            level_q   <= level_next;
            rise_q    <= rise_next;
            fall_q    <= fall_next;
            hold_q    <= hold_next;
         end
      end

      assign db_level[g]  = level_q;
      assign rise_tick[g] = rise_q;
      assign fall_tick[g] = fall_q;
      assign hold_tick[g] = hold_q;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: one instance with auto-repeat, one with a
// single hold tick, both fed the same switches.
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] sw;
   logic [1:0] db_level, rise_tick, fall_tick, hold_tick;
   logic [1:0] db_level2, rise_tick2, fall_tick2, hold_tick2;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] rise_acc, fall_acc;
   int hold2_count, hold2_first;

   debounce_multi #(
      .CH(2), .DB_CYCLES(4), .SYNC_STAGES(2),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(2'b10)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sw(sw),
      .db_level(db_level), .rise_tick(rise_tick),
      .fall_tick(fall_tick), .hold_tick(hold_tick)
   );

   debounce_multi #(
      .CH(2), .DB_CYCLES(4), .SYNC_STAGES(2),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(2'b10)
   ) dut_single (
      .clk(clk), .reset_n(reset_n), .sw(sw),
      .db_level(db_level2), .rise_tick(rise_tick2),
      .fall_tick(fall_tick2), .hold_tick(hold_tick2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick();
         rise_acc = rise_acc | rise_tick;
         fall_acc = fall_acc | fall_tick;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset with both raw inputs high; channel 1 is active-low so it reads released.
      reset_n = 1'b0;
      sw      = 2'b11;
      run(3);
      check_output("reset db_level", db_level, 2'b00);
      check_output("reset rise", rise_tick, 2'b00);
      check_output("reset hold", hold_tick, 2'b00);

      reset_n = 1'b1;
      run(5);
      check_output("t1 db before rise", db_level, 2'b00);
      tick();
      check_output("t1 db at rise", db_level, 2'b01);
      check_output("t1 rise", rise_tick, 2'b01);
      tick();
      check_output("t1 rise one cycle", rise_tick, 2'b00);

      sw = 2'b10;
      run(5);
      check_output("t1 db before fall", db_level, 2'b01);
      tick();
      check_output("t1 fall", fall_tick, 2'b01);
      check_output("t1 db after fall", db_level, 2'b00);
      tick();
      check_output("t1 fall one cycle", fall_tick, 2'b00);

      // Press bounce: never four equal samples in a row.
      rise_acc = '0;
      fall_acc = '0;
      sw = 2'b11; run(3);
      sw = 2'b10; run(1);
      sw = 2'b11; run(3);
      sw = 2'b10; run(8);
      check_output("t2 no rise on bounce", rise_acc, 2'b00);
      check_output("t2 db after bounce", db_level, 2'b00);

      sw = 2'b11;
      run(5);
      check_output("t2 db before rise", db_level, 2'b00);
      tick();
      check_output("t2 rise", rise_tick, 2'b01);

      // Release bounce; final fall lands exactly on the first hold expiry.
      rise_acc = '0;
      fall_acc = '0;
      sw = 2'b10; run(3);
      sw = 2'b11; run(1);
      sw = 2'b10; run(3);
      check_output("t2 no fall on bounce", fall_acc, 2'b00);
      run(2);
      check_output("t2 db before fall", db_level, 2'b01);
      tick();
      check_output("t2 fall", fall_tick, 2'b01);
      check_output("t2 hold suppressed", hold_tick, 2'b00);
      check_output("t2 single hold suppressed", hold_tick2, 2'b00);
      tick();
      check_output("t2 fall one cycle", fall_tick, 2'b00);

      // Long press with auto-repeat every 3 cycles after the first at +10.
      sw = 2'b11;
      run(6);
      check_output("t3 rise", rise_tick, 2'b01);
      for (int k = 1; k <= 31; k++) begin
         tick();
         check_output("t3 hold", {31'd0, hold_tick[0]},
                      {31'd0, (k >= 10) && ((k - 10) % 3 == 0)});
      end
      sw = 2'b10;
      for (int k = 32; k <= 36; k++) begin
         tick();
         check_output("t3 hold before fall", {31'd0, hold_tick[0]}, {31'd0, k == 34});
      end
      tick();
      check_output("t3 fall", fall_tick, 2'b01);
      check_output("t3 hold suppressed at fall", hold_tick, 2'b00);

      // Single-hold instance: exactly one tick over a 40-cycle press.
      sw = 2'b11;
      run(6);
      check_output("t4 rise", rise_tick2, 2'b01);
      hold2_count = 0;
      hold2_first = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (hold_tick2[0]) begin
            hold2_count++;
            if (hold2_first == 0) hold2_first = k;
         end
      end
      check_output("t4 hold count", hold2_count, 1);
      check_output("t4 hold position", hold2_first, 10);

      // Same-edge press on ch1 (active-low) and release on ch0.
      sw = 2'b00;
      run(5);
      check_output("t5 db before", db_level, 2'b01);
      tick();
      check_output("t5 rise", rise_tick, 2'b10);
      check_output("t5 fall", fall_tick, 2'b01);
      check_output("t5 db", db_level, 2'b10);
      check_output("t5 hold suppressed", hold_tick, 2'b00);
      tick();
      check_output("t5 ticks cleared", {rise_tick, fall_tick}, 4'b0000);

      // Reset while ch0 is in WAIT1 with one count left.
      sw = 2'b01;
      run(4);
      reset_n = 1'b0;
      #1;
      check_output("t6 db in reset", db_level, 2'b00);
      check_output("t6 rise in reset", rise_tick, 2'b00);
      run(2);
      reset_n = 1'b1;
      run(5);
      check_output("t6 db before rise", db_level, 2'b00);
      tick();
      check_output("t6 rise", rise_tick, 2'b11);
      check_output("t6 db", db_level, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
